// File: rtl/schmidl_cox_preamble_inserter.sv
// schmidl_cox_preamble_inserter: prepends a CP plus two identical half-symbol training halves to each AXI-Stream frame
module schmidl_cox_preamble_inserter #(
  parameter int FFT_SIZE = 1024,
  parameter int CP_LEN = 0,
  localparam int HALF = FFT_SIZE / 2,
  localparam int AW = $clog2(HALF)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          enable,
  input  logic          cfg_wr_en,
  input  logic [AW-1:0] cfg_wr_addr,
  input  logic [31:0]   cfg_wr_data,
  output logic          cfg_busy,
  input  logic [31:0]   i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          i_tready,
  output logic [31:0]   o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic [15:0]   frame_count
);
  if (FFT_SIZE < 8 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_fft
    $error("FFT_SIZE must be a power of two >= 8");
  end
  if (CP_LEN < 0 || CP_LEN > HALF) begin : g_bad_cp
    $error("CP_LEN must lie in 0..FFT_SIZE/2");
  end
  typedef enum logic [2:0] {IDLE, CP, HALF_A, HALF_B, PAYLOAD} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [31:0] ram [HALF];
  logic [31:0] ram_q;
  logic load, pre, seg_end, take_in;
  assign load = ~o_tvalid | o_tready;
  assign pre = state inside {CP, HALF_A, HALF_B};
  assign seg_end = pre & load & (ptr == AW'(HALF - 1));
  assign i_tready = (state == PAYLOAD) & load;
  assign take_in = i_tready & i_tvalid;
  // ptr is the RAM index of the next preamble beat to load; HALF is a power of two so it wraps CP->HALF_A->HALF_B for free
  assign ptr_nxt = (state == IDLE) ? AW'(HALF - CP_LEN) : ptr + AW'(pre & load);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_tvalid) state_nxt = !enable ? PAYLOAD : (CP_LEN == 0) ? HALF_A : CP;
      CP:      if (seg_end) state_nxt = HALF_A;
      HALF_A:  if (seg_end) state_nxt = HALF_B;
      HALF_B:  if (seg_end) state_nxt = PAYLOAD;
      PAYLOAD: if (take_in & i_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      o_tdata <= '0;
      o_tlast <= 1'b0;
      o_tvalid <= 1'b0;
      frame_count <= '0;
      cfg_busy <= 1'b0;
    end else begin
      cfg_busy <= state != IDLE;
      if (clear) begin
        state <= IDLE;
        ptr <= '0;
        o_tvalid <= 1'b0;
      end else begin
        state <= state_nxt;
        ptr <= ptr_nxt;
        if (seg_end && state == HALF_B) frame_count <= frame_count + 16'd1;
        if (pre & load) begin
          o_tdata <= ram_q;
          o_tlast <= 1'b0;
          o_tvalid <= 1'b1;
        end else if (take_in) begin
          o_tdata <= i_tdata;
          o_tlast <= i_tlast;
          o_tvalid <= 1'b1;
        end else if (o_tready) begin
          o_tvalid <= 1'b0;
        end
      end
    end
  end
  // Reading at ptr_nxt keeps ram_q equal to RAM[ptr] every cycle, so preamble beats stream without bubbles
  always_ff @(posedge clk) begin
    if (cfg_wr_en && !cfg_busy) ram[cfg_wr_addr] <= cfg_wr_data;
    ram_q <= ram[ptr_nxt];
  end
endmodule
